// File: rtl/barrel_result_buffer.sv
// barrel_result_buffer: captures {data, shift, dir, result} from the 4-bit barrel
//   shifter into a small first-word-fall-through FIFO and drains it to a consumer.
// Latency: an entry pushed at edge N is visible on out_* in cycle N+1 (no bypass).
// Backpressure: out_valid/out_ready handshake; a push into a full FIFO without a
//   same-cycle pop is dropped and sets the sticky overflow flag.
//
// Optional feature macro: BARREL_CHECK_EN (reference rotate self-check, per-entry
//   mismatch bit, saturating err_count). Undefined: out_mismatch/err_count tied 0.
//
// Ports:
//   clock, reset       single clock; asynchronous active-high reset clears all state
//   clr                sync clear of overflow and err_count (FIFO contents untouched)
//   in_valid, in_data, in_shift, in_dir, in_result   shifter operation to capture
//   out_valid, out_ready                             head handshake
//   out_data, out_shift, out_dir, out_result, out_mismatch   head entry fields
//   count              entries held
//   overflow           sticky dropped-push flag
//   err_count          saturating count of mismatched accepted pushes
module barrel_result_buffer #(
  parameter int DEPTH = 4,
  parameter int DW    = 4,
  parameter int SW    = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     clr,
  input  logic                     in_valid,
  input  logic [DW-1:0]            in_data,
  input  logic [SW-1:0]            in_shift,
  input  logic                     in_dir,
  input  logic [DW-1:0]            in_result,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DW-1:0]            out_data,
  output logic [SW-1:0]            out_shift,
  output logic                     out_dir,
  output logic [DW-1:0]            out_result,
  output logic                     out_mismatch,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [7:0]               err_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef struct packed {
    logic [DW-1:0] data;
    logic [SW-1:0] shift;
    logic          dir;
    logic [DW-1:0] result;
  } entry_t;

  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            overflow_q, overflow_d;

  logic            push;
  logic            pop;
  logic            full;
  entry_t          head;

  assign out_valid = (count_q != '0);
  assign full      = (count_q == DEPTH_C);
  assign pop       = out_valid && out_ready;
  // A pop frees the slot in the same cycle, so a full FIFO still accepts.
  assign push      = in_valid && (!full || pop);
  assign head      = mem_q[rd_ptr_q];

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    if (push) begin
      mem_d[wr_ptr_q] = '{data: in_data, shift: in_shift, dir: in_dir, result: in_result};
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end

    // Clear first so that a drop in the same cycle wins.
    if (clr) begin
      overflow_d = 1'b0;
    end
    if (in_valid && full && !pop) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Head fields are forced to zero while empty so stale slots never leak out.
  assign out_data   = out_valid ? head.data   : '0;
  assign out_shift  = out_valid ? head.shift  : '0;
  assign out_dir    = out_valid ? head.dir    : 1'b0;
  assign out_result = out_valid ? head.result : '0;
  assign count      = count_q;
  assign overflow   = overflow_q;

`ifdef BARREL_CHECK_EN
  logic [2*DW-1:0] dbl;
  logic [2*DW-1:0] rot_l;
  logic [2*DW-1:0] rot_r;
  logic [DW-1:0]   expected;
  logic            mismatch_in;
  logic [DEPTH-1:0] mism_q, mism_d;
  logic [7:0]       err_q, err_d;

  always_comb begin
    // Rotating via a doubled operand avoids a shift by DW when in_shift is 0.
    dbl         = {in_data, in_data};
    rot_l       = dbl << in_shift;
    rot_r       = dbl >> in_shift;
    expected    = in_dir ? rot_r[DW-1:0] : rot_l[2*DW-1:DW];
    mismatch_in = (expected != in_result);

    mism_d = mism_q;
    if (push) begin
      mism_d[wr_ptr_q] = mismatch_in;
    end

    err_d = err_q;
    if (clr) begin
      err_d = '0;
    end else if (push && mismatch_in && (err_q != 8'hFF)) begin
      err_d = err_q + 8'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mism_q <= '0;
      err_q  <= '0;
    end else begin
      mism_q <= mism_d;
      err_q  <= err_d;
    end
  end

  assign out_mismatch = out_valid & mism_q[rd_ptr_q];
  assign err_count    = err_q;
`else
  assign out_mismatch = 1'b0;
  assign err_count    = '0;
`endif

endmodule

// File: tb/tb_barrel_result_buffer.sv
module tb_barrel_result_buffer;

`ifdef BARREL_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       clr = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] in_data = '0;
  logic [1:0] in_shift = '0;
  logic       in_dir = 1'b0;
  logic [3:0] in_result = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] out_data;
  logic [1:0] out_shift;
  logic       out_dir;
  logic [3:0] out_result;
  logic       out_mismatch;
  logic [2:0] count;
  logic       overflow;
  logic [7:0] err_count;

  int n_cmp = 0;
  int n_bad = 0;

  barrel_result_buffer #(.DEPTH(4), .DW(4), .SW(2)) dut (
    .clock        (clock),
    .reset        (reset),
    .clr          (clr),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_shift     (in_shift),
    .in_dir       (in_dir),
    .in_result    (in_result),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_shift    (out_shift),
    .out_dir      (out_dir),
    .out_result   (out_result),
    .out_mismatch (out_mismatch),
    .count        (count),
    .overflow     (overflow),
    .err_count    (err_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] d, input logic [1:0] s,
                       input logic dr, input logic [3:0] r);
    in_valid  = v;
    in_data   = d;
    in_shift  = s;
    in_dir    = dr;
    in_result = r;
  endtask

  logic [3:0] q[$];
  logic [3:0] prev;

  initial begin
    // Reset state
    step();
    step();
    check("rst_count", count, 0);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_result", out_result, 0);
    check("rst_mism", out_mismatch, 0);
    check("rst_ovf", overflow, 0);
    check("rst_err", err_count, 0);
    reset = 1'b0;

    // Single push, left rotate 0011 by 1 -> 0110
    drive(1, 4'b0011, 2'd1, 0, 4'b0110);
    step();
    drive(0, 0, 0, 0, 0);
    check("single_valid", out_valid, 1);
    check("single_data", out_data, 4'b0011);
    check("single_shift", out_shift, 1);
    check("single_result", out_result, 4'b0110);
    check("single_count", count, 1);
    check("single_mism", out_mismatch, 0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("single_pop_count", count, 0);
    check("single_pop_valid", out_valid, 0);
    check("single_pop_result", out_result, 0);

    // Fill and overflow: data 1..5, entry 5 dropped
    for (int i = 1; i <= 5; i++) begin
      drive(1, 4'(i), 0, 0, 4'(i));
      step();
    end
    drive(0, 0, 0, 0, 0);
    check("fill_count", count, 4);
    check("fill_ovf", overflow, 1);
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check("fill_order", out_data, i);
      step();
    end
    out_ready = 1'b0;
    check("fill_drained", count, 0);
    check("fill_ovf_sticky", overflow, 1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("clr_ovf", overflow, 0);

    // Full with simultaneous push+pop over 8 cycles, then drain
    q.delete();
    for (int i = 1; i <= 4; i++) begin
      drive(1, 4'(i), 0, 0, 4'(i));
      q.push_back(4'(i));
      step();
    end
    out_ready = 1'b1;
    for (int i = 5; i <= 12; i++) begin
      drive(1, 4'(i), 0, 0, 4'(i));
      check("wrap_head", out_data, q.pop_front());
      q.push_back(4'(i));
      step();
      check("wrap_count", count, 4);
    end
    check("wrap_ovf", overflow, 0);
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      check("wrap_drain", out_data, q.pop_front());
      step();
    end
    out_ready = 1'b0;
    check("wrap_empty", count, 0);

    // Overflow event and clr in the same cycle: overflow ends at 1
    for (int i = 0; i < 4; i++) begin
      drive(1, 4'(i), 0, 0, 4'(i));
      step();
    end
    clr = 1'b1;
    step();
    clr = 1'b0;
    drive(0, 0, 0, 0, 0);
    check("clr_vs_ovf", overflow, 1);
    check("clr_vs_ovf_count", count, 4);
    clr = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    clr = 1'b0;
    out_ready = 1'b0;
    check("clr_vs_ovf_empty", count, 0);
    check("clr_vs_ovf_cleared", overflow, 0);

    // Self-check: right rotate 0001 by 1 -> 1000 is good, 0010 is bad
    drive(1, 4'b0001, 2'd1, 1, 4'b1000);
    step();
    check("chk_good_mism", out_mismatch, 0);
    check("chk_good_dir", out_dir, 1);
    drive(1, 4'b0001, 2'd1, 1, 4'b0010);
    out_ready = 1'b1;
    step();
    drive(0, 0, 0, 0, 0);
    out_ready = 1'b0;
    check("chk_bad_mism", out_mismatch, CHK ? 1 : 0);
    check("chk_bad_err", err_count, CHK ? 1 : 0);
    // 300 bad pushes while draining: saturates at 255
    out_ready = 1'b1;
    drive(1, 4'b0001, 2'd1, 1, 4'b0010);
    for (int i = 0; i < 300; i++) step();
    check("chk_sat_err", err_count, CHK ? 255 : 0);
    check("chk_sat_count", count, 1);
    check("chk_sat_mism", out_mismatch, CHK ? 1 : 0);
    // clr with a simultaneous increment: err_count ends at 0
    clr = 1'b1;
    step();
    clr = 1'b0;
    drive(0, 0, 0, 0, 0);
    check("chk_clr_err", err_count, 0);
    step();
    out_ready = 1'b0;
    check("chk_drained", count, 0);
    check("chk_empty_mism", out_mismatch, 0);

    // Back-to-back streaming for 20 cycles
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive(1, 4'((i * 7 + 3) & 15), 0, 0, 4'((i * 7 + 3) & 15));
      prev = 4'((i * 7 + 3) & 15);
      step();
      check("stream_count", count, 1);
      check("stream_data", out_data, prev);
    end
    drive(0, 0, 0, 0, 0);
    step();
    out_ready = 1'b0;
    check("stream_end_count", count, 0);
    check("stream_ovf", overflow, 0);

    // Reset mid-stream: 3 entries, async reset clears immediately
    for (int i = 1; i <= 3; i++) begin
      drive(1, 4'(i + 8), 0, 0, 4'(i + 8));
      step();
    end
    drive(0, 0, 0, 0, 0);
    check("pre_rst_count", count, 3);
    reset = 1'b1;
    #1;
    check("mid_rst_count", count, 0);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_data", out_data, 0);
    step();
    reset = 1'b0;
    drive(1, 4'b0101, 2'd2, 0, 4'b0101);
    step();
    drive(0, 0, 0, 0, 0);
    check("post_rst_valid", out_valid, 1);
    check("post_rst_data", out_data, 4'b0101);
    check("post_rst_shift", out_shift, 2);
    check("post_rst_count", count, 1);
    check("post_rst_mism", out_mismatch, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/barrel_result_buffer.md
# barrel_result_buffer

Downstream capture stage for the 4-bit barrel shifter. Each cycle the shifter presents a valid operation, the block stores the operand tuple {data, shift, dir} and the shifter's result in a small first-word-fall-through FIFO. It drains the FIFO to a consumer over a valid/ready handshake. It flags dropped entries on overflow and optionally self-checks every captured result against a reference rotate.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥2
- DW, 4, data/result width
- SW, 2, shift-amount width; rotate amount range 0..DW-1
- clock  in  1  single clock for all state
- reset  in  1  asynchronous, active-high; clears all state
- clr  in  1  synchronous clear of overflow and err_count only; FIFO contents untouched
- in_valid  in  1  shifter output valid this cycle
- in_data  in  DW  operand presented to shifter
- in_shift  in  SW  rotate amount
- in_dir  in  1  0 = rotate left, 1 = rotate right
- in_result  in  DW  shifter result for this operand
- out_valid  out  1  head entry available
- out_ready  in  1  consumer accepts head
- out_data / out_shift / out_dir / out_result  out  DW/SW/1/DW  head entry fields
- out_mismatch  out  1  head entry failed self-check
- count  out  $clog2(DEPTH)+1  entries held
- overflow  out  1  sticky: a push was dropped
- err_count  out  8  saturating count of mismatched pushes

## Operation
- Push = in_valid && (count < DEPTH || pop). Pop = out_valid && out_ready.
- A push accepts the whole tuple into the tail slot; the tail pointer advances modulo DEPTH.
- A pop advances the head pointer modulo DEPTH.
- count: +1 on push only, -1 on pop only, unchanged on push+pop.
- When the FIFO is full with in_valid=1 and no pop, the entry is dropped, overflow is set, and count and pointers are unchanged.
- When the FIFO is full with in_valid=1 and pop, the push is accepted.
- Empty with in_valid and out_ready: no bypass. The entry is stored, and out_valid rises the next cycle.
- out_valid = (count != 0). All out_* data fields and out_mismatch are driven 0 while out_valid=0, never X.
- overflow stays set until clr or reset. If clr and an overflow event occur in the same cycle, overflow ends at 1.
- err_count: +1 per accepted push whose mismatch bit is 1. It saturates at 255. If clr and an increment occur in the same cycle, err_count ends at 0.
- Reset mid-operation discards all entries immediately (asynchronous). The first push after reset deasserts is accepted normally.

## Timing
- Reset values: out_valid 0, all out_* 0, out_mismatch 0, count 0, overflow 0, err_count 0.
- Push latency: a tuple sampled at edge N appears at out_* with out_valid=1 after edge N (visible in cycle N+1).
- Pop takes effect at the edge where out_valid && out_ready. The next head is visible after that edge.
- Sustained throughput is 1 push + 1 pop per cycle.
- All inputs are sampled on the posedge of clock. out_* fields are read combinationally from the head slot, with no output register.

## Configuration
- BARREL_CHECK_EN defined:
  - A combinational reference computes expected = in_data rotated by in_shift (left if in_dir=0, right if in_dir=1).
  - mismatch = (expected != in_result), stored per entry and presented on out_mismatch.
  - err_count is active.
- BARREL_CHECK_EN undefined:
  - No checker logic and no per-entry mismatch storage.
  - out_mismatch and err_count are tied to 0.
  - Ports remain present.

## Test plan
- Reset mid-stream: push 3 entries, assert reset for 1 cycle -> count=0, out_valid=0, all out_* = 0 immediately; next push appears one cycle later.
- Single push, left rotate: data=4'b0011, shift=1, dir=0, result=4'b0110, out_ready=0 -> next cycle out_valid=1, out_result=0110, count=1, out_mismatch=0. Pop -> count=0, out_valid=0.
- Fill and overflow, DEPTH=4, out_ready=0: push 5 entries data=1..5 -> count=4, overflow=1; pops return data 1,2,3,4 in order; entry 5 is absent. Assert clr -> overflow=0.
- Full with simultaneous push+pop: with the FIFO full, in_valid=1 and out_ready=1 -> count stays 4, overflow stays 0, wrap-around order is preserved over 8 further cycles.
- Self-check, BARREL_CHECK_EN: right rotate data=4'b0001, shift=1, dir=1, result=4'b1000 -> out_mismatch=0. Same operand with result=4'b0010 -> out_mismatch=1, err_count=1. Push 300 bad entries while draining -> err_count=255. Without the macro -> out_mismatch=0 and err_count=0 throughout.
- Back-to-back streaming: in_valid=1 and out_ready=1 for 20 cycles -> count toggles 0→1 and then holds at 1. Outputs match inputs, delayed by 1 cycle, with no drops.
